sdp_bram_ctrl: RTL

SDP_BRAM_CTRL -- requirements
Module: sdp_bram_ctrl

---
 rtl/sdp_bram_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sdp_bram_ctrl.sv
`timescale 1ns/1ps
// Simple dual-port block-RAM controller.
// One write port with byte enables, one read-request port and a read-response
// port with ready/valid backpressure. Read responses pass through an optional
// extra pipeline register and a small skid FIFO sized so that a credit count
// alone is enough to guarantee it never overflows. After reset the array can
// be swept to zero before either port is opened.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | zero sweep over every address, one per cycle; both ports closed
// RUN   | normal operation; writes always accepted, reads while credits > 0
module sdp_bram_ctrl #(
  parameter int    RAM_WIDTH      = 512,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    RAM_DEPTH      = 16,
  parameter int    READ_LATENCY   = 1,
  parameter string COLLISION      = "WRITE_FIRST",
  parameter int    CLEAR_ON_RESET = 1,
  localparam int   NB             = RAM_WIDTH / BYTE_WIDTH,
  localparam int   AW             = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]        wr_be,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 busy
);

  // Skid FIFO holds every response that can be outstanding at once.
  localparam int FD   = READ_LATENCY + 1;
  localparam int PW   = $clog2(FD);
  localparam int CNTW = $clog2(FD + 1);
  localparam int CW   = $clog2(FD + 1);
  localparam bit WRITE_FIRST = (COLLISION == "WRITE_FIRST");

  // Reject illegal parameterisations at elaboration time.
  generate
    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("sdp_bram_ctrl: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("sdp_bram_ctrl: READ_LATENCY must be 1 or 2");
    end
    if (RAM_DEPTH < 2) begin : g_bad_depth
      $error("sdp_bram_ctrl: RAM_DEPTH must be at least 2");
    end
    if (COLLISION != "WRITE_FIRST" && COLLISION != "READ_FIRST") begin : g_bad_policy
      $error("sdp_bram_ctrl: COLLISION must be WRITE_FIRST or READ_FIRST");
    end
  endgenerate

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t ST_ENTRY = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                 state_q;
  state_t                 state_d;
  logic [AW-1:0]          clr_addr_q;
  logic                   clr_last;
  logic                   clr_we;
  logic                   busy_i;
  logic                   wr_ready_i;
  logic                   rd_req_ready_i;
  logic                   wr_fire;
  logic                   rd_fire;
  logic                   rd_pop;
  logic                   rd_valid_i;
  logic [CW-1:0]          credits_q;
  logic [RAM_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0]   cap_data;
  logic                   push_vld;
  logic [RAM_WIDTH-1:0]   push_data;
  logic [RAM_WIDTH-1:0]   fifo_mem [FD];
  logic [PW-1:0]          fifo_wr_ptr_q;
  logic [PW-1:0]          fifo_rd_ptr_q;
  logic [CNTW-1:0]        fifo_cnt_q;

  assign clr_last = (clr_addr_q == AW'(RAM_DEPTH - 1));

  // State register; reset always returns to the entry state.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q <= ST_ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and port-enable decode. Everything is forced idle while rstb
  // is high so the outputs are quiet even before the state register settles.
  always_comb begin
    state_d        = state_q;
    clr_we         = 1'b0;
    busy_i         = 1'b0;
    wr_ready_i     = 1'b0;
    rd_req_ready_i = 1'b0;
    if (!rstb) begin
      case (state_q)
        ST_CLEAR: begin
          busy_i = 1'b1;
          clr_we = 1'b1;
          if (clr_last) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          wr_ready_i     = 1'b1;
          rd_req_ready_i = (credits_q != '0);
        end
        default: begin
          state_d = ST_ENTRY;
        end
      endcase
    end
  end

  // Sweep address for the zeroing pass.
  always_ff @(posedge clka) begin
    if (rstb) begin
      clr_addr_q <= '0;
    end else if (clr_we) begin
      clr_addr_q <= clr_addr_q + AW'(1);
    end
  end

  assign wr_fire = wr_valid && wr_ready_i;
  assign rd_fire = rd_req_valid && rd_req_ready_i;
  assign rd_pop  = rd_valid_i && rd_ready;

  // Storage array; not reset so rstb alone never disturbs its contents.
  always_ff @(posedge clka) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read word captured at request accept; a same-address write in the same
  // cycle is merged in only under the write-first policy.
  always_comb begin
    cap_data = mem[rd_addr];
    if (WRITE_FIRST && wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          cap_data[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign push_vld  = rd_fire;
      assign push_data = cap_data;
    end else begin : g_lat2
      logic                 stg_vld_q;
      logic [RAM_WIDTH-1:0] stg_data_q;

      // Extra output register stage for the two-cycle latency option.
      always_ff @(posedge clka) begin
        if (rstb) begin
          stg_vld_q <= 1'b0;
        end else begin
          stg_vld_q <= rd_fire;
        end
        if (rd_fire) begin
          stg_data_q <= cap_data;
        end
      end

      assign push_vld  = stg_vld_q;
      assign push_data = stg_data_q;
    end
  endgenerate

  // Skid FIFO payload; the head entry is untouched while it waits for rd_ready.
  always_ff @(posedge clka) begin
    if (push_vld) begin
      fifo_mem[fifo_wr_ptr_q] <= push_data;
    end
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge clka) begin
    if (rstb) begin
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      if (push_vld) begin
        fifo_wr_ptr_q <= (fifo_wr_ptr_q == PW'(FD - 1)) ? '0 : fifo_wr_ptr_q + PW'(1);
      end
      if (rd_pop) begin
        fifo_rd_ptr_q <= (fifo_rd_ptr_q == PW'(FD - 1)) ? '0 : fifo_rd_ptr_q + PW'(1);
      end
      case ({push_vld, rd_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNTW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNTW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Credits track free response slots across the pipeline and the FIFO.
  always_ff @(posedge clka) begin
    if (rstb) begin
      credits_q <= CW'(FD);
    end else begin
      case ({rd_fire, rd_pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign rd_valid_i   = !rstb && (fifo_cnt_q != '0);
  assign rd_valid     = rd_valid_i;
  assign rd_data      = rd_valid_i ? fifo_mem[fifo_rd_ptr_q] : '0;
  assign wr_ready     = wr_ready_i;
  assign rd_req_ready = rd_req_ready_i;
  assign busy         = busy_i;

  // The credit scheme must keep the FIFO from ever overflowing.
  a_fifo_no_overflow: assert property (@(posedge clka) disable iff (rstb)
    (push_vld && !rd_pop) |-> (fifo_cnt_q < CNTW'(FD)));

  // Credits can never exceed the number of response slots.
  a_credit_bound: assert property (@(posedge clka) disable iff (rstb)
    credits_q <= CW'(FD));

endmodule
